// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef int unsigned num;
    typedef logic [7:0]  byte_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic num clks_per_bit(input num clk_hz, input num baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/rx_synchroniser.sv
// Two-flop synchroniser for the asynchronous rx pin plus synced falling-edge detect.
module rx_synchroniser (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // All three flops come up high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rx_s = sync2_q;
    assign fall = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_deserialiser.sv
// 8N1 UART receiver: recovers bytes from rx, strobes each good byte or framing error,
// and reports a registered line-idle level after a configurable number of byte-times.
module uart_deserialiser
    import uart_pkg::*;
#(
    parameter num clk_hz     = 50_000_000,
    parameter num baud       = 115200,
    parameter num idle_bytes = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_available,
    output logic       rx_idle,
    output logic       frame_error
);

    localparam num cpb  = clks_per_bit(clk_hz, baud);
    localparam num half = cpb / 2;
    localparam num tmo  = idle_bytes * 10 * cpb;

    localparam int unsigned CntW  = $clog2(cpb + 1);
    localparam int unsigned IdleW = $clog2(tmo + 1);

    localparam logic [CntW-1:0]  HalfC  = CntW'(half);
    localparam logic [CntW-1:0]  BitEnd = CntW'(cpb - 1);
    localparam logic [IdleW-1:0] TmoC   = IdleW'(tmo);

    if (cpb < 4) begin : g_bad_cpb
        $error("uart_deserialiser: clk_hz/baud must be at least 4");
    end

    logic rx_s;
    logic fall;

    rx_synchroniser u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    rx_state_t        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    byte_t            shift_q, shift_d;
    byte_t            data_q, data_d;
    logic             avail_q, avail_d;
    logic             ferr_q, ferr_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic             idle_q, idle_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            avail_q    <= 1'b0;
            ferr_q     <= 1'b0;
            idle_cnt_q <= TmoC;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            avail_q    <= avail_d;
            ferr_q     <= ferr_d;
            idle_cnt_q <= idle_cnt_d;
            idle_q     <= idle_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_d     = data_q;
        avail_d    = 1'b0;
        ferr_d     = 1'b0;
        idle_cnt_d = idle_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d    = START;
                    cnt_d      = '0;
                    bit_d      = '0;
                    idle_cnt_d = '0;
                end else if (rx_s && (idle_cnt_q != TmoC)) begin
                    // A low line (break) freezes the idle count rather than advancing it.
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            START: begin
                if (cnt_q == HalfC) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BitEnd) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                if (cnt_q == BitEnd) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d  = shift_q;
                        avail_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        idle_d = (idle_cnt_d == TmoC);
    end

    assign rx_data      = data_q;
    assign rx_available = avail_q;
    assign frame_error  = ferr_q;
    assign rx_idle      = idle_q;

endmodule
